// File: rtl/filter_weight_loader.sv
// filter_weight_loader
//   Receives one 3x3 filter (w0..w8) and its bias as a serial valid/ready
//   word stream. The words collect in an internal bank. They are then
//   published to the convolution datapath as nine parallel weights plus a
//   bias. The published outputs only change on a successful final
//   transfer, so the datapath keeps using the previous filter while a new
//   one streams in.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle request to begin or restart a load
//   s_valid/s_data/s_last/s_ready
//                     input word stream; the word order is w0..w8, then bias
//   wr_count          number of words accepted in the current load
//   load_done         one-cycle pulse on the publish edge
//   load_error        sticky framing error, cleared by start
//   weights_valid     the published outputs hold a complete filter
//   rdata0..rdata8    published weights w0..w8
//   bias              published bias
module filter_weight_loader #(
  parameter int numWeightFilter    = 10,
  parameter int addressWidthFilter = 4,
  parameter int dataWidthFilter    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          s_valid,
  input  logic [dataWidthFilter-1:0]    s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [addressWidthFilter-1:0] wr_count,
  output logic                          load_done,
  output logic                          load_error,
  output logic                          weights_valid,
  output logic [dataWidthFilter-1:0]    rdata0,
  output logic [dataWidthFilter-1:0]    rdata1,
  output logic [dataWidthFilter-1:0]    rdata2,
  output logic [dataWidthFilter-1:0]    rdata3,
  output logic [dataWidthFilter-1:0]    rdata4,
  output logic [dataWidthFilter-1:0]    rdata5,
  output logic [dataWidthFilter-1:0]    rdata6,
  output logic [dataWidthFilter-1:0]    rdata7,
  output logic [dataWidthFilter-1:0]    rdata8,
  output logic [dataWidthFilter-1:0]    bias
);

  localparam int NUM_W = numWeightFilter - 1;  // weights only; the last word is the bias
  localparam logic [addressWidthFilter-1:0] LAST_IDX = addressWidthFilter'(numWeightFilter - 1);
  localparam logic [addressWidthFilter-1:0] ONE      = addressWidthFilter'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                          state_reg;
  logic                            s_ready_reg;
  logic [addressWidthFilter-1:0]   wr_count_reg;
  logic                            load_done_reg;
  logic                            load_error_reg;
  logic                            weights_valid_reg;
  logic [dataWidthFilter-1:0]      bias_reg;
  logic [dataWidthFilter-1:0]      bank_reg [numWeightFilter];
  logic [dataWidthFilter-1:0]      pub_reg  [NUM_W];

  wire xfer = s_valid && s_ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      s_ready_reg       <= 1'b0;
      wr_count_reg      <= '0;
      load_done_reg     <= 1'b0;
      load_error_reg    <= 1'b0;
      weights_valid_reg <= 1'b0;
      bias_reg          <= '0;
      for (int i = 0; i < numWeightFilter; i++) bank_reg[i] <= '0;
      for (int i = 0; i < NUM_W; i++)           pub_reg[i]  <= '0;
    end else begin
      load_done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg      <= LOAD;
            s_ready_reg    <= 1'b1;
            wr_count_reg   <= '0;
            load_error_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (start) begin
            // Restart takes priority; a word offered in the same cycle is
            // dropped. Older bank entries are simply overwritten later.
            wr_count_reg   <= '0;
            load_error_reg <= 1'b0;
          end else if (xfer) begin
            if (wr_count_reg == LAST_IDX) begin
              if (s_last) begin
                // Publish edge: weights come from the bank, and the bias
                // comes straight from the word being accepted now.
                bank_reg[wr_count_reg] <= s_data;
                wr_count_reg           <= wr_count_reg + ONE;
                for (int i = 0; i < NUM_W; i++) pub_reg[i] <= bank_reg[i];
                bias_reg          <= s_data;
                weights_valid_reg <= 1'b1;
                load_done_reg     <= 1'b1;
                s_ready_reg       <= 1'b0;
                state_reg         <= DONE;
              end else begin
                // Tenth word without last: framing error, word discarded.
                load_error_reg <= 1'b1;
                s_ready_reg    <= 1'b0;
                state_reg      <= IDLE;
              end
            end else begin
              bank_reg[wr_count_reg] <= s_data;
              wr_count_reg           <= wr_count_reg + ONE;
              if (s_last) begin
                load_error_reg <= 1'b1;
                s_ready_reg    <= 1'b0;
                state_reg      <= IDLE;
              end
            end
          end
        end
        default: begin
          state_reg   <= IDLE;
          s_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready       = s_ready_reg;
  assign wr_count      = wr_count_reg;
  assign load_done     = load_done_reg;
  assign load_error    = load_error_reg;
  assign weights_valid = weights_valid_reg;
  assign bias          = bias_reg;
  assign rdata0        = pub_reg[0];
  assign rdata1        = pub_reg[1];
  assign rdata2        = pub_reg[2];
  assign rdata3        = pub_reg[3];
  assign rdata4        = pub_reg[4];
  assign rdata5        = pub_reg[5];
  assign rdata6        = pub_reg[6];
  assign rdata7        = pub_reg[7];
  assign rdata8        = pub_reg[8];

endmodule

// File: tb/tb_filter_weight_loader.sv
module tb_filter_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [3:0]  wr_count;
  logic        load_done, load_error, weights_valid;
  logic [15:0] rdata0, rdata1, rdata2, rdata3, rdata4, rdata5, rdata6, rdata7, rdata8;
  logic [15:0] bias;
  logic [15:0] rd [9];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  filter_weight_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .wr_count(wr_count), .load_done(load_done), .load_error(load_error),
    .weights_valid(weights_valid),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .rdata4(rdata4), .rdata5(rdata5), .rdata6(rdata6), .rdata7(rdata7),
    .rdata8(rdata8), .bias(bias)
  );

  assign rd[0] = rdata0; assign rd[1] = rdata1; assign rd[2] = rdata2;
  assign rd[3] = rdata3; assign rd[4] = rdata4; assign rd[5] = rdata5;
  assign rd[6] = rdata6; assign rd[7] = rdata7; assign rd[8] = rdata8;

  // Transaction-level reference: a load is a list of accepted words; a
  // complete list of nine words plus a final word marked last becomes the
  // published filter.
  logic [15:0] m_words [$];
  logic [15:0] m_pub [9];
  logic [15:0] m_bias;
  bit          m_wv, m_err, m_loading, m_done_state, m_pulse;

  function automatic void model_reset();
    m_words.delete();
    for (int i = 0; i < 9; i++) m_pub[i] = '0;
    m_bias = '0; m_wv = 0; m_err = 0; m_loading = 0; m_done_state = 0; m_pulse = 0;
  endfunction

  function automatic void model_start();
    m_words.delete();
    m_err = 0; m_loading = 1; m_done_state = 0; m_pulse = 0;
  endfunction

  function automatic void model_xfer(input logic [15:0] d, input bit last);
    m_pulse = 0;
    if (!m_loading) return;
    if (m_words.size() == 9) begin
      m_loading = 0;
      if (last) begin
        for (int i = 0; i < 9; i++) m_pub[i] = m_words[i];
        m_bias = d; m_wv = 1; m_pulse = 1; m_done_state = 1;
      end else begin
        m_err = 1;
      end
    end else begin
      m_words.push_back(d);
      if (last) begin
        m_err = 1; m_loading = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " s_ready"}, 32'(s_ready), 32'(m_loading));
    if (m_loading)         chk({tag, " wr_count"}, 32'(wr_count), 32'(m_words.size()));
    else if (m_done_state) chk({tag, " wr_count"}, 32'(wr_count), 32'd10);
    chk({tag, " load_done"}, 32'(load_done), 32'(m_pulse));
    chk({tag, " load_error"}, 32'(load_error), 32'(m_err));
    chk({tag, " weights_valid"}, 32'(weights_valid), 32'(m_wv));
    for (int i = 0; i < 9; i++) chk($sformatf("%s rdata%0d", tag, i), 32'(rd[i]), 32'(m_pub[i]));
    chk({tag, " bias"}, 32'(bias), 32'(m_bias));
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    m_pulse = 0;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic pulse_start(input string tag, input bit with_word);
    @(negedge clk);
    start = 1'b1;
    s_valid = with_word; s_data = 16'($urandom); s_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    model_start();
    @(negedge clk);
    check_all(tag);
    $display("start %s (with_word=%0b) wr_count=%0d", tag, with_word, wr_count);
  endtask

  task automatic send_word(input string tag, input logic [15:0] d, input bit last);
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    model_xfer(d, last);
    @(negedge clk);
    check_all(tag);
    $display("word %s data=%h last=%0b wr_count=%0d done=%0b err=%0b", tag, d, last, wr_count, load_done, load_error);
  endtask

  // Sends n words; s_last goes with index last_at (-1 = never).
  task automatic stream(input string tag, input logic [15:0] w [10], input int n,
                        input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_word($sformatf("%s w%0d", tag, i), w[i], (i == last_at));
      if (gaps) begin
        int g = $urandom_range(1, 2);
        for (int k = 0; k < g; k++) idle_cycle({tag, " gap"});
      end
    end
  endtask

  logic [15:0] w [10];

  initial begin
    model_reset();
    #1;
    // Reset state while rst_n is low.
    chk("reset wr_count", 32'(wr_count), 32'd0);
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;
    idle_cycle("post reset idle");

    // Single load 1..9, bias 0xFF.
    for (int i = 0; i < 9; i++) w[i] = 16'(i + 1);
    w[9] = 16'h00FF;
    pulse_start("load1", 0);
    stream("load1", w, 10, 9, 0);
    idle_cycle("load1 done low");

    // Same stream with gaps.
    pulse_start("gaps", 0);
    stream("gaps", w, 10, 9, 1);
    idle_cycle("gaps after");

    // Early last on the fourth word.
    w[0] = 16'h0101; w[1] = 16'h0202; w[2] = 16'h0303; w[3] = 16'hAAAA;
    pulse_start("early", 0);
    stream("early", w, 4, 3, 0);
    idle_cycle("early idle");

    // Missing last: ten words of 0x1111.
    for (int i = 0; i < 10; i++) w[i] = 16'h1111;
    pulse_start("missing", 0);
    stream("missing", w, 10, -1, 0);
    idle_cycle("missing idle");
    pulse_start("missing clear", 0);

    // Reload shadowing: restart (from LOAD) and stream F000..F009.
    for (int i = 0; i < 10; i++) w[i] = 16'hF000 + 16'(i);
    pulse_start("reload", 0);
    stream("reload", w, 10, 9, 0);

    // Abort after five words, then a full random stream.
    for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
    pulse_start("abort", 0);
    stream("abort part", w, 5, -1, 0);
    pulse_start("abort restart", 0);
    for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
    stream("abort full", w, 10, 9, 1);

    // start with a simultaneous word offered: the word is dropped.
    pulse_start("startword a", 0);
    stream("startword part", w, 3, -1, 0);
    pulse_start("startword b", 1);
    for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
    stream("startword full", w, 10, 9, 0);

    // Random loads with random gaps.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
      pulse_start($sformatf("rand%0d", r), 0);
      stream($sformatf("rand%0d", r), w, 10, 9, 1);
    end

    // Reset mid-load.
    pulse_start("rstmid", 0);
    stream("rstmid", w, 3, -1, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstmid wr_count", 32'(wr_count), 32'd0);
    check_all("rstmid async");
    $display("reset asserted mid-load s_ready=%0b weights_valid=%0b", s_ready, weights_valid);
    @(negedge clk); rst_n = 1'b1;
    idle_cycle("rstmid release");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/filter_weight_loader.md
Name: filter_weight_loader

Overview:
- Write-side counterpart of the CNN filter weight ROM.
- Accepts one 3x3 filter's weights plus its bias as a serial word stream from the SoC, using a valid/ready handshake with a last flag.
- Stores the words in an internal bank, then atomically publishes them as nine parallel weights plus bias to the convolution datapath.
- The datapath keeps using the previous filter while a new one streams in, so filters can be reloaded at runtime without resynthesis.

Parameters:
- numWeightFilter, 10, words per filter (9 weights + 1 bias); only 10 is supported.
- addressWidthFilter, 4, width of the word counter; 2^addressWidthFilter >= numWeightFilter.
- dataWidthFilter, 16, width of each weight/bias word (two's-complement fixed point, passed through untouched).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin (or restart) a load.
- s_valid  in  1  stream word valid.
- s_data  in  dataWidthFilter  stream word; order is w0..w8, then bias.
- s_last  in  1  marks the final (bias) word.
- s_ready  out  1  loader accepts a word this cycle.
- wr_count  out  addressWidthFilter  words accepted in the current load.
- load_done  out  1  one-cycle pulse on successful publish.
- load_error  out  1  sticky framing error; cleared by start.
- weights_valid  out  1  published outputs hold a complete filter.
- rdata0..rdata8  out  dataWidthFilter each  published weights w0..w8.
- bias  out  dataWidthFilter  published bias.

Behaviour:
- Reset (async assert, sync release): state IDLE; s_ready, wr_count, load_done, load_error, weights_valid, rdata0..8, bias and the bank all 0.
- Handshake: a word transfers on a rising edge with s_valid && s_ready. s_data and s_last are sampled only on a transfer. The sender holds s_data and s_last stable while s_valid && !s_ready.
- States:
  - IDLE: s_ready=0. start -> LOAD, wr_count<=0, load_error<=0.
  - LOAD: s_ready=1 (registered, high from the cycle after start). Each transfer writes bank[wr_count]<=s_data and increments wr_count.
    - Transfer at wr_count<9 with s_last=1 -> early last: load_error<=1, go IDLE.
    - Transfer at wr_count==9 with s_last=1 -> go DONE. In the same edge, rdata0..8 <= bank[0..8], bias <= s_data, weights_valid<=1, load_done<=1 for that one cycle.
    - Transfer at wr_count==9 with s_last=0 -> missing last: load_error<=1, go IDLE, word discarded.
    - start in LOAD: restart, with wr_count<=0 and the bank partially stale. start wins over a simultaneous transfer, and that word is dropped.
  - DONE: s_ready=0; wr_count holds 10. start -> LOAD with wr_count<=0.
- Atomic publish: the outputs change only on the successful-publish edge. Errors and aborts leave rdata0..8, bias and weights_valid unchanged.
- weights_valid: 0 only from reset until the first successful load; it stays 1 afterwards, including during reloads and errors.
- Latency: final transfer at edge N -> outputs, weights_valid and load_done visible after edge N; load_done is low again after N+1.
- No arithmetic: words are stored and forwarded bit-exact. wr_count never wraps; the maximum value is 10.
- Reset mid-load: everything returns to reset values, and previously published weights are lost.

Test Plan:
- Reset then single load: start, stream 0x0001..0x0009 then bias 0x00FF with s_last on the 10th word -> rdata0=0x0001 … rdata8=0x0009, bias=0x00FF; load_done high exactly 1 cycle; weights_valid=1; wr_count=10.
- Backpressure-free gaps: same stream with s_valid low on alternate cycles -> identical outputs; wr_count increments only on transfers.
- Early last: after a good load of 0x0001..0x00FF, start and send 4 words with s_last on the 4th (0xAAAA) -> load_error=1, state IDLE, outputs still 0x0001..0x00FF, no load_done.
- Missing last: 10 words of 0x1111 with s_last=0 -> load_error=1, outputs unchanged. Then start -> load_error=0.
- Reload shadowing: after a good load, start and stream 0xF000..0xF009 while monitoring the outputs -> outputs hold the old values through word 9 and switch to 0xF000..0xF008 with bias 0xF009 on the final edge.
- Abort and reset: start mid-load after 5 words, then a full stream -> correct publish with wr_count restarted at 0. Separately, assert rst_n=0 mid-load -> all outputs 0 immediately and s_ready=0.
